// File: rtl/parser_pkg.sv
// parser_pkg
// Definitions shared by the PHV extractor:
//   - bit positions of the fields inside a 16-bit parse action
//   - action type encodings and their byte counts
//   - container count and PHV slot offsets
//   - FSM state encoding
package parser_pkg;

    localparam int ACT_W        = 16;
    localparam int ACT_OFF_LSB  = 7;   // [13:7] byte offset
    localparam int ACT_OFF_W    = 7;
    localparam int ACT_TYPE_LSB = 5;   // [6:5]  container type
    localparam int ACT_IDX_LSB  = 2;   // [3:2]  container index
    localparam int ACT_VLD_BIT  = 0;   // [0]    action valid

    localparam int NUM_CONT     = 4;   // containers per type
    localparam int MAX_BYTE     = 128; // bytes at or above this index read as zero
    localparam int FIELD_W      = 48;  // widest container, in bits

    localparam int PHV_W        = 512;
    localparam int PHV_6B_TOP   = 511; // 6B container k at [511-48k -: 48]
    localparam int PHV_4B_TOP   = 319; // 4B container k at [319-32k -: 32]
    localparam int PHV_2B_TOP   = 191; // 2B container k at [191-16k -: 16]
    localparam int PHV_TUSER_W  = 128; // metadata at [127:0]

    typedef enum logic [1:0] {
        ACT_2B   = 2'b00,
        ACT_4B   = 2'b01,
        ACT_6B   = 2'b10,
        ACT_NONE = 2'b11
    } act_type_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXTRACT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    typedef struct packed {
        logic [ACT_OFF_W-1:0] off;
        act_type_t            typ;
        logic [1:0]           idx;
        logic                 vld;
    } action_t;

    function automatic action_t decode_action(input logic [ACT_W-1:0] raw);
        action_t a;
        a.off = raw[ACT_OFF_LSB +: ACT_OFF_W];
        a.typ = act_type_t'(raw[ACT_TYPE_LSB +: 2]);
        a.idx = raw[ACT_IDX_LSB +: 2];
        a.vld = raw[ACT_VLD_BIT];
        return a;
    endfunction

    function automatic int type_bytes(input act_type_t t);
        case (t)
            ACT_2B:  return 2;
            ACT_4B:  return 4;
            ACT_6B:  return 6;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/parser_byte_sel.sv
// parser_byte_sel
// Combinational field fetch from the captured header window.
// Returns up to six bytes starting at 'offset', left-aligned in a 48-bit
// field (byte 'offset' lands in [47:40]). Bytes past the size of the
// selected type, past index 127, or past the window end read as zero.
// Ports:
//   window   : header window, byte n = bits [8n +: 8]
//   offset   : starting byte offset 0..127
//   act_type : container type, selects how many bytes are fetched
//   field    : left-aligned big-endian field
module parser_byte_sel
    import parser_pkg::*;
#(
    parameter int WIN_W = 1024
) (
    input  logic [WIN_W-1:0]     window,
    input  logic [ACT_OFF_W-1:0] offset,
    input  act_type_t            act_type,
    output logic [FIELD_W-1:0]   field
);

    logic [WIN_W-1:0] shifted;
    int               nbytes;

    always_comb begin
        // Shifting the window down puts byte 'offset' at [7:0]; bytes shifted
        // in from above the window are zero, which covers a short window.
        shifted = window >> {offset, 3'b000};
        nbytes  = type_bytes(act_type);
        field   = '0;
        for (int j = 0; j < FIELD_W / 8; j++) begin
            if ((j < nbytes) && ((int'(offset) + j) < MAX_BYTE)) begin
                field[FIELD_W-1-8*j -: 8] = shifted[8*j +: 8];
            end
        end
    end

endmodule

// File: rtl/parser_extract_phv.sv
// parser_extract_phv
// Captures one header window plus first-beat metadata, applies a list of
// C_NUM_ACTS parse actions (one per cycle) to fill 2B/4B/6B containers, and
// presents the assembled 512-bit PHV until downstream accepts it.
// Ports:
//   axis_clk, aresetn   : clock, synchronous active-low reset
//   tdata_segs          : header window, byte n = bits [8n +: 8]
//   tuser_1st           : metadata copied into PHV [127:0]
//   segs_valid          : one-cycle window pulse, taken only in IDLE
//   segs_fifo_ready     : high exactly while IDLE
//   parse_action        : action list, action i = bits [16i +: 16]
//   parse_action_valid  : one-cycle action-list pulse
//   phv_out, phv_valid  : extracted PHV and its valid flag
//   phv_ready           : downstream accept, honoured only in EMIT
//   err_seq             : sticky: window with no actions, or window outside IDLE
//   err_act_ovf         : sticky: action list dropped because pending was full
module parser_extract_phv
    import parser_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_SEGS         = 4,
    parameter int C_NUM_ACTS         = 10
) (
    input  logic                                  axis_clk,
    input  logic                                  aresetn,
    input  logic [C_NUM_SEGS*C_AXIS_DATA_WIDTH-1:0] tdata_segs,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]         tuser_1st,
    input  logic                                  segs_valid,
    output logic                                  segs_fifo_ready,
    input  logic [ACT_W*C_NUM_ACTS-1:0]           parse_action,
    input  logic                                  parse_action_valid,
    output logic [PHV_W-1:0]                      phv_out,
    output logic                                  phv_valid,
    input  logic                                  phv_ready,
    output logic                                  err_seq,
    output logic                                  err_act_ovf
);

    localparam int WIN_W  = C_NUM_SEGS * C_AXIS_DATA_WIDTH;
    localparam int ACTS_W = ACT_W * C_NUM_ACTS;
    localparam int CNT_W  = (C_NUM_ACTS > 1) ? $clog2(C_NUM_ACTS) : 1;

    state_t                        state;
    logic                          pend_vld;
    logic [ACTS_W-1:0]             pend_acts;
    logic [ACTS_W-1:0]             work_acts;   // current action always in [15:0]
    logic [CNT_W-1:0]              act_cnt;
    logic [WIN_W-1:0]              win_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_q;
    logic [47:0]                   cont_6b [NUM_CONT];
    logic [31:0]                   cont_4b [NUM_CONT];
    logic [15:0]                   cont_2b [NUM_CONT];

    action_t                       cur_act;
    logic [FIELD_W-1:0]            cur_field;
    logic                          start;

    assign cur_act = decode_action(work_acts[ACT_W-1:0]);
    assign start   = (state == ST_IDLE) && segs_valid;

    parser_byte_sel #(
        .WIN_W (WIN_W)
    ) u_byte_sel (
        .window   (win_q),
        .offset   (cur_act.off),
        .act_type (cur_act.typ),
        .field    (cur_field)
    );

    // PHV is a pure rewiring of registered containers, so it only moves
    // while extracting and is stable throughout EMIT.
    always_comb begin
        phv_out = '0;
        for (int k = 0; k < NUM_CONT; k++) begin
            phv_out[PHV_6B_TOP-48*k -: 48] = cont_6b[k];
            phv_out[PHV_4B_TOP-32*k -: 32] = cont_4b[k];
            phv_out[PHV_2B_TOP-16*k -: 16] = cont_2b[k];
        end
        phv_out[PHV_TUSER_W-1:0] = PHV_TUSER_W'(tuser_q);
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            segs_fifo_ready <= 1'b1;
            pend_vld        <= 1'b0;
            pend_acts       <= '0;
            work_acts       <= '0;
            act_cnt         <= '0;
            tuser_q         <= '0;
            phv_valid       <= 1'b0;
            err_seq         <= 1'b0;
            err_act_ovf     <= 1'b0;
            for (int k = 0; k < NUM_CONT; k++) begin
                cont_6b[k] <= '0;
                cont_4b[k] <= '0;
                cont_2b[k] <= '0;
            end
        end else begin
            // Pending list: a list arriving in the same cycle that pending is
            // consumed refills it; a list arriving at start with pending empty
            // goes straight to working and never touches pending.
            if (start && pend_vld) begin
                pend_vld <= parse_action_valid;
                if (parse_action_valid) begin
                    pend_acts <= parse_action;
                end
            end else if (parse_action_valid && !start) begin
                if (!pend_vld) begin
                    pend_vld  <= 1'b1;
                    pend_acts <= parse_action;
                end else begin
                    err_act_ovf <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (segs_valid) begin
                        win_q           <= tdata_segs;
                        tuser_q         <= tuser_1st;
                        act_cnt         <= '0;
                        segs_fifo_ready <= 1'b0;
                        state           <= ST_EXTRACT;
                        for (int k = 0; k < NUM_CONT; k++) begin
                            cont_6b[k] <= '0;
                            cont_4b[k] <= '0;
                            cont_2b[k] <= '0;
                        end
                        if (pend_vld) begin
                            work_acts <= pend_acts;
                        end else if (parse_action_valid) begin
                            work_acts <= parse_action;
                        end else begin
                            work_acts <= '0;
                            err_seq   <= 1'b1;
                        end
                    end
                end

                ST_EXTRACT: begin
                    if (segs_valid) begin
                        err_seq <= 1'b1;
                    end
                    if (cur_act.vld) begin
                        case (cur_act.typ)
                            ACT_2B:  cont_2b[cur_act.idx] <= cur_field[FIELD_W-1 -: 16];
                            ACT_4B:  cont_4b[cur_act.idx] <= cur_field[FIELD_W-1 -: 32];
                            ACT_6B:  cont_6b[cur_act.idx] <= cur_field;
                            default: ;
                        endcase
                    end
                    work_acts <= work_acts >> ACT_W;
                    act_cnt   <= act_cnt + CNT_W'(1);
                    if (act_cnt == CNT_W'(C_NUM_ACTS - 1)) begin
                        state     <= ST_EMIT;
                        phv_valid <= 1'b1;
                    end
                end

                ST_EMIT: begin
                    if (segs_valid) begin
                        err_seq <= 1'b1;
                    end
                    if (phv_ready) begin
                        phv_valid       <= 1'b0;
                        segs_fifo_ready <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    segs_fifo_ready <= 1'b1;
                    phv_valid       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parser_extract_phv.sv
// tb_parser_extract_phv
// Directed bench for parser_extract_phv with default parameters
// (1024-bit window, 10 actions). Inputs are driven and outputs sampled on
// the falling edge of axis_clk.
module tb_parser_extract_phv;

    localparam int N_ACTS = 10;

    logic           axis_clk = 1'b0;
    logic           aresetn  = 1'b0;
    logic [1023:0]  tdata_segs = '0;
    logic [127:0]   tuser_1st = '0;
    logic           segs_valid = 1'b0;
    logic           segs_fifo_ready;
    logic [159:0]   parse_action = '0;
    logic           parse_action_valid = 1'b0;
    logic [511:0]   phv_out;
    logic           phv_valid;
    logic           phv_ready = 1'b0;
    logic           err_seq;
    logic           err_act_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    logic [1023:0] win;
    logic [127:0]  tu;
    logic [159:0]  acts_a, acts_b, acts_c, acts_c2;
    logic [511:0]  exp_phv;
    logic          seen;

    parser_extract_phv #(
        .C_AXIS_DATA_WIDTH  (256),
        .C_AXIS_TUSER_WIDTH (128),
        .C_NUM_SEGS         (4),
        .C_NUM_ACTS         (N_ACTS)
    ) dut (
        .axis_clk           (axis_clk),
        .aresetn            (aresetn),
        .tdata_segs         (tdata_segs),
        .tuser_1st          (tuser_1st),
        .segs_valid         (segs_valid),
        .segs_fifo_ready    (segs_fifo_ready),
        .parse_action       (parse_action),
        .parse_action_valid (parse_action_valid),
        .phv_out            (phv_out),
        .phv_valid          (phv_valid),
        .phv_ready          (phv_ready),
        .err_seq            (err_seq),
        .err_act_ovf        (err_act_ovf)
    );

    always #5 axis_clk = ~axis_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk_act(input int off, input int typ, input int idx, input bit vld);
        logic [15:0] a;
        a       = '0;
        a[13:7] = 7'(off);
        a[6:5]  = 2'(typ);
        a[3:2]  = 2'(idx);
        a[0]    = vld;
        return a;
    endfunction

    // Presents a window for one cycle; with_acts also presents an action list
    // in the same cycle. Returns at the falling edge after the accepting edge.
    task automatic start_packet(input logic [1023:0] w, input logic [127:0] t,
                                input logic [159:0] acts, input bit with_acts);
        tdata_segs         = w;
        tuser_1st          = t;
        segs_valid         = 1'b1;
        parse_action       = acts;
        parse_action_valid = with_acts;
        @(negedge axis_clk);
        segs_valid         = 1'b0;
        parse_action_valid = 1'b0;
    endtask

    task automatic pulse_acts(input logic [159:0] acts);
        parse_action       = acts;
        parse_action_valid = 1'b1;
        @(negedge axis_clk);
        parse_action_valid = 1'b0;
    endtask

    // Counts clock edges after the accepting edge until phv_valid rises.
    task automatic wait_phv(input string tag, input int already);
        int cnt;
        cnt = already;
        while (!phv_valid && cnt < 40) begin
            @(negedge axis_clk);
            cnt++;
        end
        check(tag, 512'(cnt), 512'(N_ACTS));
    endtask

    task automatic accept(input string tag);
        phv_ready = 1'b1;
        @(negedge axis_clk);
        phv_ready = 1'b0;
        check({tag, "_valid_drop"}, 512'(phv_valid), 512'(0));
        check({tag, "_fifo_rdy"}, 512'(segs_fifo_ready), 512'(1));
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge axis_clk);
        check("rst_fifo_rdy", 512'(segs_fifo_ready), 512'(1));
        check("rst_phv_valid", 512'(phv_valid), 512'(0));
        check("rst_phv_out", phv_out, 512'(0));
        check("rst_err_seq", 512'(err_seq), 512'(0));
        check("rst_err_ovf", 512'(err_act_ovf), 512'(0));
        aresetn = 1'b1;
        @(negedge axis_clk);

        // 2B extraction, action list given with the window
        win = '0;
        win[8*12 +: 8] = 8'h81;
        win[8*13 +: 8] = 8'h00;
        tu = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        acts_a = '0;
        acts_a[15:0] = mk_act(12, 0, 0, 1);
        start_packet(win, tu, acts_a, 1'b1);
        check("a_fifo_busy", 512'(segs_fifo_ready), 512'(0));
        wait_phv("a_latency", 0);
        exp_phv = '0;
        exp_phv[191:176] = 16'h8100;
        exp_phv[127:0]   = tu;
        check("a_phv", phv_out, exp_phv);
        check("a_err_seq", 512'(err_seq), 512'(0));
        accept("a");

        // 6B at the top of the window; type-11 and invalid actions write nothing
        win = '0;
        win[8*126 +: 8] = 8'hAA;
        win[8*127 +: 8] = 8'hBB;
        win[7:0]        = 8'h55;
        tu = 128'h1;
        acts_b = '0;
        acts_b[15:0]  = mk_act(126, 2, 3, 1);
        acts_b[31:16] = mk_act(0, 3, 0, 1);
        acts_b[47:32] = mk_act(0, 0, 1, 0);
        start_packet(win, tu, acts_b, 1'b1);
        wait_phv("b_latency", 0);
        exp_phv = '0;
        exp_phv[367:320] = 48'hAABB_0000_0000;
        exp_phv[127:0]   = tu;
        check("b_phv", phv_out, exp_phv);
        accept("b");

        // pending list; overwrite of 4B c1; pending refilled in the consume cycle
        acts_c = '0;
        acts_c[15:0]  = mk_act(0, 1, 1, 1);
        acts_c[31:16] = mk_act(4, 1, 1, 1);
        acts_c2 = '0;
        acts_c2[15:0] = mk_act(127, 0, 3, 1);
        pulse_acts(acts_c);
        check("c_ovf_after_load", 512'(err_act_ovf), 512'(0));
        win = '0;
        for (int i = 0; i < 8; i++) win[8*i +: 8] = 8'(i + 1);
        win[8*127 +: 8] = 8'hEE;
        tu = 128'hCAFE;
        start_packet(win, tu, acts_c2, 1'b1);
        check("c_ovf_refill", 512'(err_act_ovf), 512'(0));
        wait_phv("c_latency", 0);
        exp_phv = '0;
        exp_phv[287:256] = 32'h0506_0708;
        exp_phv[127:0]   = tu;
        check("c_phv", phv_out, exp_phv);
        for (int i = 0; i < 20; i++) begin
            @(negedge axis_clk);
            check("c_hold_valid", 512'(phv_valid), 512'(1));
            check("c_hold_phv", phv_out, exp_phv);
            check("c_hold_fifo", 512'(segs_fifo_ready), 512'(0));
        end
        accept("c");

        // refilled pending list: 2B c3 at offset 127, byte 128 reads zero
        start_packet(win, tu, '0, 1'b0);
        check("c2_err_seq", 512'(err_seq), 512'(0));
        wait_phv("c2_latency", 0);
        exp_phv = '0;
        exp_phv[143:128] = 16'hEE00;
        exp_phv[127:0]   = tu;
        check("c2_phv", phv_out, exp_phv);
        accept("c2");

        // three lists without a window: first kept, overflow flagged
        acts_a = '0;
        acts_a[15:0] = mk_act(20, 0, 2, 1);
        pulse_acts(acts_a);
        check("e_ovf_first", 512'(err_act_ovf), 512'(0));
        acts_b = '0;
        acts_b[15:0] = mk_act(30, 0, 2, 1);
        pulse_acts(acts_b);
        check("e_ovf_second", 512'(err_act_ovf), 512'(1));
        pulse_acts(acts_b);
        check("e_ovf_sticky", 512'(err_act_ovf), 512'(1));
        win = '0;
        win[8*20 +: 8] = 8'h12;
        win[8*21 +: 8] = 8'h34;
        win[8*30 +: 8] = 8'h9A;
        win[8*31 +: 8] = 8'hBC;
        tu = 128'h77;
        start_packet(win, tu, '0, 1'b0);
        check("e_err_seq_before", 512'(err_seq), 512'(0));
        // window presented during EXTRACT must be ignored
        start_packet({1024{1'b1}}, {128{1'b1}}, '0, 1'b0);
        check("e_err_seq_after", 512'(err_seq), 512'(1));
        wait_phv("e_latency", 1);
        exp_phv = '0;
        exp_phv[159:144] = 16'h1234;
        exp_phv[127:0]   = tu;
        check("e_phv", phv_out, exp_phv);
        accept("e");

        // reset in the middle of EXTRACT
        acts_a = '0;
        acts_a[15:0] = mk_act(12, 0, 0, 1);
        win = '0;
        win[8*12 +: 8] = 8'h81;
        tu = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        start_packet(win, tu, acts_a, 1'b1);
        repeat (4) @(negedge axis_clk);
        aresetn = 1'b0;
        @(negedge axis_clk);
        check("f_rst_valid", 512'(phv_valid), 512'(0));
        check("f_rst_fifo", 512'(segs_fifo_ready), 512'(1));
        aresetn = 1'b1;
        phv_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge axis_clk);
            if (phv_valid) seen = 1'b1;
        end
        phv_ready = 1'b0;
        check("f_no_phv", 512'(seen), 512'(0));
        check("f_fifo_rdy", 512'(segs_fifo_ready), 512'(1));
        check("f_errs_clear", 512'({err_seq, err_act_ovf}), 512'(0));
        check("f_phv_cleared", phv_out, 512'(0));

        // next packet after reset is correct
        start_packet(win, tu, acts_a, 1'b1);
        wait_phv("f_latency", 0);
        exp_phv = '0;
        exp_phv[191:176] = 16'h8100;
        exp_phv[127:0]   = tu;
        check("f_phv", phv_out, exp_phv);
        accept("f");

        // window with no action list anywhere
        tu = 128'h5A5A;
        start_packet(win, tu, '0, 1'b0);
        check("g_err_seq", 512'(err_seq), 512'(1));
        wait_phv("g_latency", 0);
        exp_phv = '0;
        exp_phv[127:0] = tu;
        check("g_phv", phv_out, exp_phv);
        accept("g");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
